scsi_io_arb: RTL and testbench
==============================

# scsi_io_arb

Sector-request arbiter between two `scsi` target instances and the single HPS block-device channel. It sits directly downstream of each target's `io_lba`/`io_rd`/`io_wr`/`io_ack` and sector-buffer ports. It grants one target at a time in round-robin order and drives the HPS `sd_lba`/`sd_rd`/`sd_wr` handshake. It steers the HPS buffer traffic to the granted target and returns a one-cycle `io_ack` when the HPS transfer completes.

## Interface
Parameters:
- `TMO_LOG2`, default 22: watchdog length exponent; timeout = 2^TMO_LOG2 cycles (used only with `SCSI_ARB_TIMEOUT_EN`).

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `t_lba` in 64: `{t1 io_lba, t0 io_lba}`.
- `t_rd` in 2: per-target `io_rd`.
- `t_wr` in 2: per-target `io_wr`.
- `t_ack` out 2: per-target `io_ack`; one-cycle pulse.
- `t_buff_din` in 16: `{t1 sd_buff_din, t0 sd_buff_din}` (target read-back data).
- `t_buff_wr` out 2: per-target `sd_buff_wr`.
- `sd_lba` out 32: sector address to HPS.
- `sd_rd` out 1: read request to HPS.
- `sd_wr` out 1: write request to HPS.
- `sd_ack` in 1: HPS busy/ack level.
- `sd_buff_wr` in 1: HPS buffer write strobe.
- `sd_buff_din` out 8: data to HPS = `t_buff_din` byte of the granted target.
- `grant` out 1: index of the granted or last-granted target.
- `tmo_err` out 1: sticky watchdog error flag.

`sd_buff_addr`/`sd_buff_dout` fan out directly to both targets and are not routed through this block.

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- **IDLE**
  - Request vector `r[i] = t_rd[i] | t_wr[i]`.
  - If both targets request, grant the one not equal to `grant`. If one requests, grant it.
  - Latch `sd_lba <= t_lba[i]` and `dir <= t_rd[i]`. Read wins if a target shows both `rd` and `wr`.
  - Go to ISSUE.
- **ISSUE**
  - `sd_rd = dir`, `sd_wr = !dir`.
  - Go to XFER on `sd_ack == 1`.
- **XFER**
  - `sd_rd = sd_wr = 0`.
  - `t_buff_wr[grant] = sd_buff_wr`; the other target's bit is 0.
  - `sd_buff_din = t_buff_din[grant*8 +: 8]` (combinational).
  - Go to DONE on `sd_ack == 0`.
- **DONE**
  - `t_ack[grant] = 1` for exactly one cycle.
  - Return to IDLE.
- Request sampling: requests are level-sampled only in IDLE. A target's request seen in IDLE on the cycle after DONE is a new request, because the target clears `io_rd`/`io_wr` on `io_ack`.
- `sd_lba` is held constant from grant until the next grant.
- `t_buff_wr` is 0 in every state except XFER.
- Reset values:
  - State IDLE, `sd_rd = sd_wr = 0`, `t_ack = 0`, `t_buff_wr = 0`.
  - `grant = 1`, so t0 wins the first tie.
  - `sd_lba = 0`, `tmo_err = 0`.
- Reset mid-transfer: return to IDLE immediately. No `t_ack` is issued. The HPS may still pulse `sd_buff_wr`, and it is ignored.

## Timing
- Request to `sd_rd`/`sd_wr`: request high in IDLE at cycle N gives `sd_rd`/`sd_wr` high from cycle N+1.
- `sd_ack` rise at N gives `sd_rd`/`sd_wr` low at N+1.
- `sd_ack` fall at N gives `t_ack` high at N+1 and low at N+2. The next grant can happen at N+2 at the earliest.
- `sd_buff_wr` to `t_buff_wr`: zero latency (combinational) in XFER.
- `sd_buff_din`: zero added latency; the target's buffer already registers it.
- Simultaneous requests: strict alternation. Back-to-back requests from one target are served consecutively if the other target is idle.
- `sd_ack` high while in IDLE: ignored; no state change.

## Configuration
- `SCSI_ARB_TIMEOUT_EN` defined:
  - A counter of width TMO_LOG2+1 clears on entry to ISSUE and runs in ISSUE and XFER.
  - When bit TMO_LOG2 sets: `sd_rd = sd_wr = 0`, `tmo_err <= 1` (sticky until `reset`), then DONE, so the target receives `t_ack` and does not hang.
- `SCSI_ARB_TIMEOUT_EN` undefined:
  - No counter is built.
  - `tmo_err` is tied to 0.
  - ISSUE and XFER wait indefinitely.

## Test plan
- **Single read:** t0 `rd`, lba 0x1234 → next cycle `sd_lba = 0x1234`, `sd_rd = 1`. HPS raises `sd_ack`, then 512 `sd_buff_wr` → `t_buff_wr[0]` mirrors all 512 strobes and `t_buff_wr[1]` stays 0. `sd_ack` falls → `t_ack = 2'b01` for exactly 1 cycle.
- **Write read-back steering:** t1 `wr`, lba 7, `t_buff_din = {8'hA5, 8'h3C}` → `sd_wr = 1`, `grant = 1`, `sd_buff_din = 8'hA5` in XFER. Completion gives `t_ack = 2'b10`.
- **Simultaneous requests after reset:** both `rd` in the same cycle after reset → t0 served first, t1 second. Repeat 4 rounds → grant order 0,1,0,1,0,1,0,1.
- **Reset mid-XFER:** assert `reset` in XFER, then deassert and drop `sd_ack` → no `t_ack` pulse, `sd_rd = sd_wr = 0`, state IDLE, and a new t0 request is granted normally.
- **Timeout (macro on, TMO_LOG2 = 4):** t0 `rd`, HPS never raises `sd_ack` → `sd_rd` drops and `t_ack[0]` pulses about 17 cycles after the request, and `tmo_err = 1` stays set.
- **Timeout disabled (macro off):** same stimulus → `sd_rd` stays high for 1000 cycles and `tmo_err = 0`.

Source files
------------

// File: rtl/scsi_io_arb.sv
// Round-robin arbiter sharing one HPS block-device channel between two scsi targets.
// Optional watchdog built when SCSI_ARB_TIMEOUT_EN is defined.
module scsi_io_arb #(
  parameter int unsigned TMO_LOG2 = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] t_lba,
  input  logic [1:0]  t_rd,
  input  logic [1:0]  t_wr,
  output logic [1:0]  t_ack,
  input  logic [15:0] t_buff_din,
  output logic [1:0]  t_buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        grant,
  output logic        tmo_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic [1:0] req;
  logic       sel;
  logic       dir;
  logic       tmo_hit;

  assign req = t_rd | t_wr;

  // On a tie the target that was not served last wins.
  always_comb begin
    sel = grant;
    if (req == 2'b11)
      sel = ~grant;
    else if (req[0])
      sel = 1'b0;
    else if (req[1])
      sel = 1'b1;
  end

`ifdef SCSI_ARB_TIMEOUT_EN
  logic [TMO_LOG2:0] tmo_cnt;

  assign tmo_hit = tmo_cnt[TMO_LOG2];

  // Held at zero in IDLE so it starts from zero on every entry to ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == S_ISSUE || state == S_XFER) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_hit)
          tmo_err <= 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= 1'b1;
      sd_lba <= '0;
      dir    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant  <= sel;
            sd_lba <= sel ? t_lba[63:32] : t_lba[31:0];
            dir    <= t_rd[sel];
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tmo_hit)
            state <= S_DONE;
          else if (sd_ack)
            state <= S_XFER;
        end
        S_XFER: begin
          if (tmo_hit || !sd_ack)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sd_rd       = (state == S_ISSUE) &&  dir && !tmo_hit;
    sd_wr       = (state == S_ISSUE) && !dir && !tmo_hit;
    t_buff_wr   = '0;
    t_ack       = '0;
    sd_buff_din = grant ? t_buff_din[15:8] : t_buff_din[7:0];
    if (state == S_XFER)
      t_buff_wr = {grant & sd_buff_wr, ~grant & sd_buff_wr};
    if (state == S_DONE)
      t_ack = {grant, ~grant};
  end

endmodule

// File: tb/tb_scsi_io_arb.sv
// Randomized bench for scsi_io_arb: the bench plays both targets and the HPS and
// predicts grants from pending-request bookkeeping.
module tb_scsi_io_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] t_lba;
  logic [1:0]  t_rd, t_wr, t_ack, t_buff_wr;
  logic [15:0] t_buff_din;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr, grant, tmo_err;
  logic [7:0]  sd_buff_din;

  int tests = 0;
  int fails = 0;

  // Target-side bookkeeping: what each target is currently asking for.
  logic [1:0]  pend_rd, pend_wr;
  logic [31:0] pend_lba [2];
  int          last;
  bit          after_done;

`ifdef SCSI_ARB_TIMEOUT_EN
  localparam int BIG = 8;
`else
  localparam int BIG = 512;
`endif

  always #5 clk = ~clk;

  scsi_io_arb #(.TMO_LOG2(4)) dut (
    .clk(clk), .reset(reset), .t_lba(t_lba), .t_rd(t_rd), .t_wr(t_wr),
    .t_ack(t_ack), .t_buff_din(t_buff_din), .t_buff_wr(t_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .grant(grant),
    .tmo_err(tmo_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    t_rd  = pend_rd;
    t_wr  = pend_wr;
    t_lba = {pend_lba[1], pend_lba[0]};
  endtask

  task automatic add_random();
    logic [1:0] kind;
    for (int i = 0; i < 2; i++) begin
      if (!(pend_rd[i] | pend_wr[i]) && $urandom_range(0, 1) == 1) begin
        kind        = 2'($urandom_range(1, 3));
        pend_rd[i]  = kind[0];
        pend_wr[i]  = kind[1];
        pend_lba[i] = $urandom;
      end
    end
  endtask

  // Present pending requests so the next IDLE cycle samples them.
  task automatic start_req();
    if ((pend_rd | pend_wr) == 2'b00) begin
      drive_reqs();
      if (after_done) begin
        @(negedge clk);
        chk("ack_len", t_ack, 0);
        after_done = 0;
      end
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        sd_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_rw", {sd_rd, sd_wr}, 0);
      end
      sd_ack = 1'b0;
      while ((pend_rd | pend_wr) == 2'b00) add_random();
    end
    drive_reqs();
    if (after_done) begin
      @(negedge clk);
      chk("ack_len", t_ack, 0);
      chk("idle_rw", {sd_rd, sd_wr}, 0);
      after_done = 0;
    end
  endtask

  task automatic run_round(input int np, input int dly, input bit dense, input bit abort);
    int w;
    logic [1:0] pend;
    logic [1:0] exp_rw;
    start_req();
    pend = pend_rd | pend_wr;
    w = (pend == 2'b11) ? (last == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
    exp_rw = pend_rd[w] ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("grant", grant, 64'(w));
    chk("sd_lba", sd_lba, pend_lba[w]);
    chk("issue_rw", {sd_rd, sd_wr}, exp_rw);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("issue_hold", {sd_rd, sd_wr}, exp_rw);
    end
    sd_ack = 1'b1;
    @(negedge clk);
    chk("xfer_rw", {sd_rd, sd_wr}, 0);
    for (int k = 0; k < np; k++) begin
      t_buff_din = 16'($urandom);
      sd_buff_wr = dense ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      chk("t_buff_wr", t_buff_wr, sd_buff_wr ? (2'b01 << w) : 2'b00);
      chk("sd_buff_din", sd_buff_din, (t_buff_din >> (8 * w)) & 16'h00ff);
      @(negedge clk);
    end
    sd_buff_wr = 1'b0;
    if (abort) begin
      reset      = 1'b1;
      sd_buff_wr = 1'b1;
      pend_rd    = '0;
      pend_wr    = '0;
      drive_reqs();
      @(negedge clk);
      chk("rst_ack", t_ack, 0);
      chk("rst_bwr", t_buff_wr, 0);
      chk("rst_rw", {sd_rd, sd_wr}, 0);
      chk("rst_grant", grant, 1);
      reset  = 1'b0;
      sd_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("rst_no_ack", t_ack, 0);
        chk("rst_no_bwr", t_buff_wr, 0);
        chk("rst_idle", {sd_rd, sd_wr}, 0);
      end
      sd_buff_wr = 1'b0;
      last       = 1;
      after_done = 0;
      return;
    end
    sd_ack = 1'b0;
    @(negedge clk);
    chk("t_ack", t_ack, 2'b01 << w);
    chk("done_rw", {sd_rd, sd_wr}, 0);
    pend_rd[w] = 1'b0;
    pend_wr[w] = 1'b0;
    last       = w;
    after_done = 1;
    drive_reqs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    int hi;
    reset      = 1'b1;
    pend_rd    = '0;
    pend_wr    = '0;
    pend_lba[0] = '0;
    pend_lba[1] = '0;
    last       = 1;
    after_done = 0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b1;
    t_buff_din = '0;
    drive_reqs();
    repeat (3) @(negedge clk);
    chk("rst_rw", {sd_rd, sd_wr}, 0);
    chk("rst_t_ack", t_ack, 0);
    chk("rst_t_buff_wr", t_buff_wr, 0);
    chk("rst_grant", grant, 1);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_tmo_err", tmo_err, 0);
    sd_buff_wr = 1'b0;
    reset      = 1'b0;

    // Tie straight after reset: t0 first.
    pend_rd = 2'b11; pend_lba[0] = 32'h1111; pend_lba[1] = 32'h2222;
    run_round(2, 0, 0, 0);
    run_round(2, 1, 0, 0);

    // Single read with a full sector of strobes.
    pend_rd[0] = 1'b1; pend_lba[0] = 32'h1234;
    run_round(BIG, 2, 1, 0);

    // Write from t1 with read-back steering.
    pend_wr[1] = 1'b1; pend_lba[1] = 32'd7;
    run_round(4, 1, 0, 0);

    // Strict alternation while both keep requesting.
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < 2; t++) begin
        if (!(pend_rd[t] | pend_wr[t])) begin
          pend_rd[t]  = 1'b1;
          pend_lba[t] = $urandom;
        end
      end
      run_round(2, 0, 0, 0);
    end
    pend_rd = '0; pend_wr = '0;

    for (int i = 0; i < 60; i++) begin
      add_random();
      run_round(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 0, 0);
    end
    pend_rd = '0; pend_wr = '0;

    // Reset in the middle of XFER, then a normal t0 request.
    pend_rd[0] = 1'b1; pend_lba[0] = 32'hdead;
    run_round(3, 1, 0, 1);
    pend_rd[0] = 1'b1; pend_lba[0] = 32'hbeef;
    run_round(3, 0, 0, 0);

    // HPS never answers.
    pend_rd[0] = 1'b1; pend_lba[0] = 32'h55;
    start_req();
    hi = 0;
`ifdef SCSI_ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (sd_rd) hi++;
    end
    chk("tmo_rd_high", hi, 16);
    @(negedge clk);
    chk("tmo_rd_drop", {sd_rd, sd_wr}, 0);
    @(negedge clk);
    chk("tmo_ack", t_ack, 2'b01);
    chk("tmo_err_set", tmo_err, 1);
    @(negedge clk);
    chk("tmo_ack_len", t_ack, 0);
    pend_rd = '0; pend_wr = '0; drive_reqs();
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", tmo_err, 1);
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sd_rd) hi++;
    end
    chk("no_tmo_rd_high", hi, 1000);
    chk("no_tmo_err", tmo_err, 0);
    sd_ack = 1'b1;
    @(negedge clk);
    sd_ack = 1'b0;
    @(negedge clk);
    chk("no_tmo_ack", t_ack, 2'b01);
    pend_rd = '0; pend_wr = '0; drive_reqs();
    @(negedge clk);
    chk("no_tmo_ack_len", t_ack, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
